paula_audio_mix_sequencer: RTL and testbench

// - Time-multiplexes one shared signed 8x7 multiplier across the 4 Paula audio channels.
// - Builds the 15-bit left/right sums (ldatasum/rdatasum) fed to the stereo sigma-delta modulator.
// - One mix frame per frame_req (upstream issues one every 16 clk7_en ticks, the modulator's interpolation period).
// - Routing: channels 0,3 -> left; channels 1,2 -> right (LEFT_MASK).

---
 rtl/paula_audio_mix_sequencer_pkg.sv | 31 +++
 rtl/paula_audio_mix_sequencer_if.sv | 25 ++
 rtl/paula_audio_mix_sequencer_vol_mul.sv | 22 ++
 rtl/paula_audio_mix_sequencer.sv | 119 +++++++++++
 tb/tb_paula_audio_mix_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/paula_audio_mix_sequencer_pkg.sv
// Shared constants and state type for the Paula audio mix sequencer.
package paula_audio_pkg;

  localparam int AUD_SW = 8;                    // channel sample width (signed)
  localparam int AUD_VW = 7;                    // channel volume width (unsigned, 0..64)
  localparam int AUD_OW = AUD_SW + AUD_VW;      // output sum width (signed)
  localparam int AUD_PW = AUD_SW + AUD_VW - 1;  // single-channel product width

  localparam logic [3:0]        AUD_LEFT_MASK = 4'b1001;
  localparam logic [AUD_VW-1:0] AUD_VOL_MAX   = AUD_VW'(64);

  // Legacy encodings kept so existing probes and dumps keep their values
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_MAC0   = 3'd2;
  localparam logic [2:0] ST_MAC1   = 3'd3;
  localparam logic [2:0] ST_MAC2   = 3'd4;
  localparam logic [2:0] ST_MAC3   = 3'd5;
  localparam logic [2:0] ST_COMMIT = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    MAC0   = ST_MAC0,
    MAC1   = ST_MAC1,
    MAC2   = ST_MAC2,
    MAC3   = ST_MAC3,
    COMMIT = ST_COMMIT
  } state_e;

endpackage

// File: rtl/paula_audio_mix_sequencer_if.sv
// Frame request, channel inputs and stereo sum outputs of the mix sequencer.
interface paula_audio_mix_sequencer_if;
  import paula_audio_pkg::*;

  logic                       frame_req;
  logic [4*AUD_SW-1:0]        sample;
  logic [4*AUD_VW-1:0]        volume;
  logic [3:0]                 mute;
  logic signed [AUD_OW-1:0]   ldatasum;
  logic signed [AUD_OW-1:0]   rdatasum;
  logic                       sum_valid;
  logic                       busy;
  logic                       overrun;

  modport master (
    output frame_req, sample, volume, mute,
    input  ldatasum, rdatasum, sum_valid, busy, overrun
  );

  modport slave (
    input  frame_req, sample, volume, mute,
    output ldatasum, rdatasum, sum_valid, busy, overrun
  );

endinterface

// File: rtl/paula_audio_mix_sequencer_vol_mul.sv
// Combinational signed sample x clamped unsigned volume multiplier.
module paula_audio_vol_mul
  import paula_audio_pkg::*;
(
  input  logic signed [AUD_SW-1:0] sample_i,
  input  logic        [AUD_VW-1:0] volume_i,
  output logic signed [AUD_PW-1:0] product_o
);

  logic [AUD_VW-1:0]        vol_clamped;
  logic signed [AUD_PW-1:0] s_ext;
  logic signed [AUD_PW-1:0] v_ext;

  // Volume bit 6 set means full scale; the product always fits AUD_PW bits
  always_comb begin
    vol_clamped = volume_i[AUD_VW-1] ? AUD_VOL_MAX : volume_i;
    s_ext       = AUD_PW'(sample_i);
    v_ext       = AUD_PW'($signed({1'b0, vol_clamped}));
    product_o   = s_ext * v_ext;
  end

endmodule

// File: rtl/paula_audio_mix_sequencer.sv
// Sequences four audio channels through one shared multiplier into left/right sums.
module paula_audio_mix_sequencer
  import paula_audio_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clk7_en,
  paula_audio_mix_sequencer_if.slave  bus
);

  state_e                    state_q, state_d;
  logic [4*AUD_SW-1:0]       snap_sample_q;
  logic [4*AUD_VW-1:0]       snap_volume_q;
  logic [3:0]                snap_mute_q;
  logic signed [AUD_OW-1:0]  accl_q, accr_q;
  logic signed [AUD_OW-1:0]  ldatasum_q, rdatasum_q;
  logic                      sum_valid_q;
  logic                      pending_q;
  logic                      overrun_q;

  logic                      busy;
  logic                      mac_active;
  logic [1:0]                ch;
  logic signed [AUD_SW-1:0]  mul_sample;
  logic [AUD_VW-1:0]         mul_volume;
  logic signed [AUD_PW-1:0]  mul_prod;
  logic signed [AUD_OW-1:0]  addend;

  assign busy = (state_q != IDLE);

  // Select which channel's snapshot feeds the shared multiplier this tick
  always_comb begin
    mac_active = 1'b1;
    ch         = 2'd0;
    case (state_q)
      MAC0:    ch = 2'd0;
      MAC1:    ch = 2'd1;
      MAC2:    ch = 2'd2;
      MAC3:    ch = 2'd3;
      default: mac_active = 1'b0;
    endcase
    mul_sample = snap_sample_q[ch*AUD_SW +: AUD_SW];
    mul_volume = snap_volume_q[ch*AUD_VW +: AUD_VW];
    addend     = snap_mute_q[ch] ? '0 : AUD_OW'(mul_prod);
  end

  paula_audio_vol_mul u_vol_mul (
    .sample_i  (mul_sample),
    .volume_i  (mul_volume),
    .product_o (mul_prod)
  );

  // Frame sequencing: one step per clk7_en tick, back-to-back when a request is queued
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.frame_req) state_d = LOAD;
      LOAD:    state_d = MAC0;
      MAC0:    state_d = MAC1;
      MAC1:    state_d = MAC2;
      MAC2:    state_d = MAC3;
      MAC3:    state_d = COMMIT;
      COMMIT:  state_d = (pending_q || bus.frame_req) ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state, request queueing and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      sum_valid_q <= 1'b0;
      ldatasum_q  <= '0;
      rdatasum_q  <= '0;
    end else begin
      sum_valid_q <= 1'b0;
      if (clk7_en) begin
        state_q <= state_d;
        if (state_q == COMMIT) begin
          pending_q   <= 1'b0;
          sum_valid_q <= 1'b1;
          ldatasum_q  <= accl_q;
          rdatasum_q  <= accr_q;
        end else if (busy && bus.frame_req) begin
          if (pending_q) overrun_q <= 1'b1;
          else           pending_q <= 1'b1;
        end
      end
    end
  end

  // Input snapshot at LOAD and per-channel accumulation during MAC0..MAC3
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      accl_q <= '0;
      accr_q <= '0;
    end else if (clk7_en) begin
      if (state_q == LOAD) begin
        snap_sample_q <= bus.sample;
        snap_volume_q <= bus.volume;
        snap_mute_q   <= bus.mute;
        accl_q        <= '0;
        accr_q        <= '0;
      end else if (mac_active) begin
        if (AUD_LEFT_MASK[ch]) accl_q <= accl_q + addend;
        else                   accr_q <= accr_q + addend;
      end
    end
  end

  assign bus.ldatasum  = ldatasum_q;
  assign bus.rdatasum  = rdatasum_q;
  assign bus.sum_valid = sum_valid_q;
  assign bus.busy      = busy;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_paula_audio_mix_sequencer.sv
// Directed and randomized checks of the audio mix sequencer against a sum-of-products model.
module tb_paula_audio_mix_sequencer;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic clk7_en = 1'b0;

  always #5 clk = ~clk;

  paula_audio_mix_sequencer_if bus ();

  paula_audio_mix_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk7_en (clk7_en),
    .bus     (bus)
  );

  int         n_tests  = 0;
  int         n_fail   = 0;
  int         sv_count = 0;
  logic       sv1, sv2;
  logic [3:0] left_mask = 4'b1001;

  int cs[4];
  int cv[4];
  int cm;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clk7_en tick, then one disabled clk with a random (must be ignored) frame_req
  task automatic tick(input logic fr);
    @(negedge clk);
    clk7_en       = 1'b1;
    bus.frame_req = fr;
    @(posedge clk); #1;
    sv1 = bus.sum_valid;
    @(negedge clk);
    clk7_en       = 1'b0;
    bus.frame_req = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    sv2 = bus.sum_valid;
    bus.frame_req = 1'b0;
    sv_count += int'(sv1) + int'(sv2);
  endtask

  task automatic apply();
    for (int n = 0; n < 4; n++) begin
      bus.sample[n*8 +: 8] = 8'(cs[n]);
      bus.volume[n*7 +: 7] = 7'(cv[n]);
    end
    bus.mute = 4'(cm);
  endtask

  task automatic randomize_inputs();
    for (int n = 0; n < 4; n++) begin
      cs[n] = int'($urandom_range(0, 255)) - 128;
      cv[n] = int'($urandom_range(0, 127));
    end
    cm = int'($urandom_range(0, 15));
  endtask

  task automatic set_all(input int s0, s1, s2, s3, v0, v1, v2, v3, m);
    cs[0] = s0; cs[1] = s1; cs[2] = s2; cs[3] = s3;
    cv[0] = v0; cv[1] = v1; cv[2] = v2; cv[3] = v3;
    cm = m;
  endtask

  // Reference: sum of sample*min(volume,64) over unmuted channels, split by routing mask
  function automatic void model(output int l, output int r);
    l = 0;
    r = 0;
    for (int n = 0; n < 4; n++) begin
      int vc;
      int p;
      vc = (cv[n] >= 64) ? 64 : cv[n];
      p  = cm[n] ? 0 : cs[n] * vc;
      if (left_mask[n]) l += p;
      else              r += p;
    end
  endfunction

  task automatic run_frame(input string tag, input bit scramble);
    int l, r, c0;
    model(l, r);
    apply();
    c0 = sv_count;
    tick(1'b1);                           // request accepted
    chk({tag, "_busy"}, bus.busy, 1);
    tick(1'b0);                           // LOAD snapshot
    if (scramble) begin
      randomize_inputs();
      apply();
    end
    repeat (4) tick(1'b0);                // four multiply-accumulate ticks
    chk({tag, "_novalid_early"}, sv_count, c0);
    tick(1'b0);                           // sums appear
    chk({tag, "_valid"}, sv1, 1);
    chk({tag, "_valid_1clk"}, sv2, 0);
    chk({tag, "_ldatasum"}, $signed(bus.ldatasum), l);
    chk({tag, "_rdatasum"}, $signed(bus.rdatasum), r);
    chk({tag, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int la, ra, lb, rb, c0, hl, hr;

    bus.frame_req = 1'b0;
    set_all(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply();

    // Reset held over three enabled ticks with frame_req asserted
    reset_n = 1'b0;
    repeat (3) tick(1'b1);
    chk("rst_ldatasum", $signed(bus.ldatasum), 0);
    chk("rst_rdatasum", $signed(bus.rdatasum), 0);
    chk("rst_sum_valid", bus.sum_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    @(negedge clk);
    reset_n  = 1'b1;
    sv_count = 0;
    repeat (8) tick(1'b0);
    chk("post_rst_no_valid", sv_count, 0);
    chk("post_rst_idle", bus.busy, 0);

    // Directed frames
    set_all(127, 127, -128, -128, 64, 64, 64, 64, 0);
    run_frame("single", 1'b0);
    set_all(-128, -128, -128, -128, 64, 64, 64, 64, 0);
    run_frame("min", 1'b0);
    set_all(127, 127, 127, 127, 127, 127, 127, 127, 0);
    run_frame("max_clamp", 1'b0);
    set_all(100, 50, 50, 50, 10, 1, 1, 1, 4'b0100);
    run_frame("mute_route", 1'b0);
    hl = 1050;
    hr = 50;
    repeat (5) tick(1'b0);
    chk("hold_ldatasum", $signed(bus.ldatasum), hl);
    chk("hold_rdatasum", $signed(bus.rdatasum), hr);
    set_all(-7, 33, 90, -100, 40, 64, 100, 17, 4'b0000);
    run_frame("snapshot", 1'b1);

    // Randomized frames, inputs also scrambled right after the snapshot
    for (int k = 0; k < 8; k++) begin
      randomize_inputs();
      run_frame($sformatf("rand%0d", k), 1'b1);
    end

    // Queued second request: starts right after the first commit, no overrun
    set_all(10, 20, 30, 40, 64, 64, 64, 64, 0);
    model(la, ra);
    apply();
    c0 = sv_count;
    tick(1'b1);                           // T
    tick(1'b0);                           // T+1 LOAD
    set_all(-50, 60, -70, 80, 33, 12, 127, 5, 4'b0010);
    model(lb, rb);
    apply();
    tick(1'b1);                           // T+2 queued
    chk("q_overrun_clear", bus.overrun, 0);
    repeat (3) tick(1'b0);                // T+3..T+5
    tick(1'b0);                           // T+6 first commit
    chk("q1_valid", sv1, 1);
    chk("q1_ldatasum", $signed(bus.ldatasum), la);
    chk("q1_rdatasum", $signed(bus.rdatasum), ra);
    chk("q1_busy_next", bus.busy, 1);
    repeat (5) tick(1'b0);                // T+7..T+11
    chk("q2_no_early_valid", sv_count, c0 + 1);
    tick(1'b0);                           // T+12 second commit
    chk("q2_valid", sv1, 1);
    chk("q2_ldatasum", $signed(bus.ldatasum), lb);
    chk("q2_rdatasum", $signed(bus.rdatasum), rb);
    chk("q2_idle", bus.busy, 0);
    chk("q2_overrun", bus.overrun, 0);

    // Third request while one is already queued sets sticky overrun
    tick(1'b1);                           // T
    tick(1'b0);                           // T+1 LOAD
    tick(1'b1);                           // T+2 queued
    chk("ov_not_yet", bus.overrun, 0);
    tick(1'b1);                           // T+3 dropped
    chk("ov_set", bus.overrun, 1);
    tick(1'b0);                           // T+4, now in the third multiply step
    chk("ov_sticky", bus.overrun, 1);

    // Reset mid-frame on a clk with clk7_en low
    @(negedge clk);
    clk7_en = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ldatasum", $signed(bus.ldatasum), 0);
    chk("mid_rst_rdatasum", $signed(bus.rdatasum), 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_overrun", bus.overrun, 0);
    chk("mid_rst_valid", bus.sum_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    c0 = sv_count;
    repeat (10) tick(1'b0);
    chk("mid_rst_no_frame", sv_count, c0);
    chk("mid_rst_still_idle", bus.busy, 0);

    set_all(-128, 127, -1, 1, 64, 63, 127, 0, 4'b1000);
    run_frame("resume", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
